hdlc_rx_drain_ctrl: RTL and testbench

//  Autonomous register-bus master that services the Hdlc receive path. On Rx_Ready it

---
 rtl/hdlc_rx_drain_ctrl.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_hdlc_rx_drain_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdlc_rx_drain_ctrl.sv
// hdlc_rx_drain_ctrl: autonomous register-bus master for the Hdlc receive path; streams good frames
// as valid/ready bytes and discards bad ones. Define HDLC_RXDRAIN_STATS_EN to add frame_cnt/drop_cnt.

module hdlc_rx_drain_ctrl #(
   parameter int unsigned RD_LAT   = 1,
   parameter int unsigned MAX_LEN  = 126,
   parameter logic [2:0]  A_RX_SC  = 3'h2,
   parameter logic [2:0]  A_RX_BUF = 3'h3,
   parameter logic [2:0]  A_RX_LEN = 3'h4
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        enable,
   input  logic        Rx_Ready,
   output logic [2:0]  Address,
   output logic        WriteEnable,
   output logic        ReadEnable,
   output logic [7:0]  DataIn,
   input  logic [7:0]  DataOut,
   output logic [7:0]  m_data,
   output logic        m_valid,
   output logic        m_last,
   input  logic        m_ready,
   output logic        err_valid,
   output logic [2:0]  err_code,
   output logic        busy
`ifdef HDLC_RXDRAIN_STATS_EN
   ,
   output logic [15:0] frame_cnt,
   output logic [15:0] drop_cnt
`endif
);

   localparam logic [2:0] ERR_NONE  = 3'd0;
   localparam logic [2:0] ERR_ABORT = 3'd1;
   localparam logic [2:0] ERR_FCS   = 3'd2;
   localparam logic [2:0] ERR_OVF   = 3'd3;
   localparam logic [2:0] ERR_LEN   = 3'd4;
   localparam logic [7:0] DROP_CMD  = 8'h02;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
   localparam logic [1:0] LAT_END   = 2'(RD_LAT);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_RD_SC    = 3'd1,
      S_RD_LEN   = 3'd2,
      S_RD_BYTE  = 3'd3,
      S_PUSH     = 3'd4,
      S_DROP     = 3'd5,
      S_WAIT_CLR = 3'd6
   } state_t;

   // st = Rx_SC[4:2]; abort outranks frame error, which outranks overflow
   function automatic logic [2:0] sc_err_code(input logic [2:0] st);
      logic [2:0] code;
      if (st[1]) begin
         code = ERR_ABORT;
      end else if (st[0]) begin
         code = ERR_FCS;
      end else if (st[2]) begin
         code = ERR_OVF;
      end else begin
         code = ERR_NONE;
      end
      return code;
   endfunction

   state_t     state_q, state_d;
   logic [1:0] lat_q, lat_d;
   logic [7:0] cnt_q, cnt_d;
   logic [2:0] addr_q, addr_d;
   logic       re_q, re_d;
   logic       we_q, we_d;
   logic [7:0] din_q, din_d;
   logic [7:0] m_data_q, m_data_d;
   logic       m_valid_q, m_valid_d;
   logic       m_last_q, m_last_d;
   logic       err_valid_q, err_valid_d;
   logic [2:0] err_code_q, err_code_d;
   logic       busy_q, busy_d;

   logic       lat_done_s;
   logic [2:0] sc_code_s;
   logic       len_bad_s;

   assign lat_done_s = (lat_q == LAT_END);
   assign sc_code_s  = sc_err_code(DataOut[4:2]);
   assign len_bad_s  = (DataOut == 8'd0) || (DataOut > MAX_LEN_B);

   // Next-state logic; strobes, Address and DataIn default to 0 so each strobe is a single cycle
   always_comb begin
      state_d     = state_q;
      lat_d       = lat_q;
      cnt_d       = cnt_q;
      addr_d      = 3'd0;
      re_d        = 1'b0;
      we_d        = 1'b0;
      din_d       = 8'd0;
      m_data_d    = m_data_q;
      m_valid_d   = m_valid_q;
      m_last_d    = m_last_q;
      err_valid_d = 1'b0;
      err_code_d  = err_code_q;
      busy_d      = busy_q;

      case (state_q)
         S_IDLE: begin
            if (enable && Rx_Ready) begin
               state_d = S_RD_SC;
               re_d    = 1'b1;
               addr_d  = A_RX_SC;
               lat_d   = 2'd0;
               busy_d  = 1'b1;
            end else begin
               busy_d  = 1'b0;
            end
         end

         S_RD_SC: begin
            if (!lat_done_s) begin
               lat_d = lat_q + 2'd1;
            end else if (sc_code_s != ERR_NONE) begin
               state_d     = S_DROP;
               we_d        = 1'b1;
               addr_d      = A_RX_SC;
               din_d       = DROP_CMD;
               err_valid_d = 1'b1;
               err_code_d  = sc_code_s;
            end else begin
               state_d = S_RD_LEN;
               re_d    = 1'b1;
               addr_d  = A_RX_LEN;
               lat_d   = 2'd0;
            end
         end

         S_RD_LEN: begin
            if (!lat_done_s) begin
               lat_d = lat_q + 2'd1;
            end else if (len_bad_s) begin
               state_d     = S_DROP;
               we_d        = 1'b1;
               addr_d      = A_RX_SC;
               din_d       = DROP_CMD;
               err_valid_d = 1'b1;
               err_code_d  = ERR_LEN;
            end else begin
               state_d = S_RD_BYTE;
               cnt_d   = DataOut;
               re_d    = 1'b1;
               addr_d  = A_RX_BUF;
               lat_d   = 2'd0;
            end
         end

         S_RD_BYTE: begin
            if (lat_done_s) begin
               state_d   = S_PUSH;
               m_data_d  = DataOut;
               m_valid_d = 1'b1;
               m_last_d  = (cnt_q == 8'd1);
            end else begin
               lat_d = lat_q + 2'd1;
            end
         end

         // Byte pending: nothing changes until the consumer takes it
         S_PUSH: begin
            if (m_ready) begin
               m_valid_d = 1'b0;
               m_last_d  = 1'b0;
               cnt_d     = cnt_q - 8'd1;
               if (cnt_q > 8'd1) begin
                  state_d = S_RD_BYTE;
                  re_d    = 1'b1;
                  addr_d  = A_RX_BUF;
                  lat_d   = 2'd0;
               end else begin
                  state_d = S_WAIT_CLR;
               end
            end else begin
               state_d = S_PUSH;
            end
         end

         S_DROP: begin
            state_d = S_WAIT_CLR;
         end

         // Wait for the serviced frame's Rx_Ready to clear before looking for the next one
         S_WAIT_CLR: begin
            if (!Rx_Ready) begin
               state_d = S_IDLE;
               busy_d  = 1'b0;
            end else begin
               state_d = S_WAIT_CLR;
            end
         end

         default: begin
            state_d   = S_IDLE;
            busy_d    = 1'b0;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
         end
      endcase
   end

   // FSM state and registered outputs
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q     <= S_IDLE;
         lat_q       <= 2'd0;
         cnt_q       <= 8'd0;
         addr_q      <= 3'd0;
         re_q        <= 1'b0;
         we_q        <= 1'b0;
         din_q       <= 8'd0;
         m_data_q    <= 8'd0;
         m_valid_q   <= 1'b0;
         m_last_q    <= 1'b0;
         err_valid_q <= 1'b0;
         err_code_q  <= 3'd0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         lat_q       <= lat_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         re_q        <= re_d;
         we_q        <= we_d;
         din_q       <= din_d;
         m_data_q    <= m_data_d;
         m_valid_q   <= m_valid_d;
         m_last_q    <= m_last_d;
         err_valid_q <= err_valid_d;
         err_code_q  <= err_code_d;
         busy_q      <= busy_d;
      end
   end

   assign Address     = addr_q;
   assign ReadEnable  = re_q;
   assign WriteEnable = we_q;
   assign DataIn      = din_q;
   assign m_data      = m_data_q;
   assign m_valid     = m_valid_q;
   assign m_last      = m_last_q;
   assign err_valid   = err_valid_q;
   assign err_code    = err_code_q;
   assign busy        = busy_q;

`ifdef HDLC_RXDRAIN_STATS_EN
   logic [15:0] frame_cnt_q, frame_cnt_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;

   // Saturating frame/drop counters
   always_comb begin
      frame_cnt_d = frame_cnt_q;
      drop_cnt_d  = drop_cnt_q;
      if ((state_q == S_PUSH) && m_ready && m_last_q && (frame_cnt_q != 16'hFFFF)) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
      end else begin
         frame_cnt_d = frame_cnt_q;
      end
      if (err_valid_q && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end
   end

   // Statistics registers
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         frame_cnt_q <= 16'd0;
         drop_cnt_q  <= 16'd0;
      end else begin
         frame_cnt_q <= frame_cnt_d;
         drop_cnt_q  <= drop_cnt_d;
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign drop_cnt  = drop_cnt_q;
`endif

endmodule

// File: tb/tb_hdlc_rx_drain_ctrl.sv
// Self-checking bench for hdlc_rx_drain_ctrl: Hdlc register model, byte scoreboard,
// table of frames plus hand-written reset/enable/stats sequences.

module tb_hdlc_rx_drain_ctrl;
   localparam int LAT  = 1;
   localparam int MAXL = 126;

   logic       Clk = 1'b0;
   logic       Rst = 1'b1;
   logic       enable = 1'b0;
   logic       Rx_Ready = 1'b0;
   logic       m_ready = 1'b1;
   logic [2:0] Address;
   logic       WriteEnable, ReadEnable;
   logic [7:0] DataIn, DataOut;
   logic [7:0] m_data;
   logic       m_valid, m_last, err_valid, busy;
   logic [2:0] err_code;
`ifdef HDLC_RXDRAIN_STATS_EN
   logic [15:0] frame_cnt, drop_cnt;
`endif

   always #5 Clk = ~Clk;

   hdlc_rx_drain_ctrl #(.RD_LAT(LAT), .MAX_LEN(MAXL)) dut (
      .Clk(Clk), .Rst(Rst), .enable(enable), .Rx_Ready(Rx_Ready),
      .Address(Address), .WriteEnable(WriteEnable), .ReadEnable(ReadEnable),
      .DataIn(DataIn), .DataOut(DataOut),
      .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
      .err_valid(err_valid), .err_code(err_code), .busy(busy)
`ifdef HDLC_RXDRAIN_STATS_EN
      , .frame_cnt(frame_cnt), .drop_cnt(drop_cnt)
`endif
   );

   int n_chk = 0;
   int n_fail = 0;

   function automatic void chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // ---------------- Hdlc register model ----------------
   logic [7:0] sc_reg = 8'h00, len_reg = 8'h00, base_reg = 8'h00;
   logic [7:0] pipe [LAT];
   int         bptr = 0;
   int         cyc = 0;

   assign DataOut = pipe[LAT-1];

   function automatic logic [7:0] model_read(input logic [2:0] a, input int p);
      case (a)
         3'h2:    return sc_reg;
         3'h4:    return len_reg;
         3'h3:    return base_reg + 8'(p * 17);
         default: return 8'hEE;
      endcase
   endfunction

   initial begin
      forever begin
         @(posedge Clk);
         cyc <= cyc + 1;
         for (int i = LAT - 1; i > 0; i--) pipe[i] <= pipe[i-1];
         pipe[0] <= ReadEnable ? model_read(Address, bptr) : 8'hEE;
         if (ReadEnable && Address == 3'h2) bptr <= 0;
         else if (ReadEnable && Address == 3'h3) bptr <= bptr + 1;
      end
   end

   // ---------------- bus monitor and byte scoreboard ----------------
   typedef struct { logic [7:0] d; logic l; } exp_t;
   exp_t exp_q[$];
   int   n_reads = 0, n_writes = 0, n_errs = 0, acc_total = 0, acc_base = 0, last_acc_cyc = 0;
   bit   gap_en = 1'b0;
   logic [2:0] last_code = 3'd0;

   initial begin
      logic       prev_pend, prev_re, prev_err, prev_last;
      logic [7:0] prev_data;
      exp_t       e;
      prev_pend = 1'b0; prev_re = 1'b0; prev_err = 1'b0; prev_last = 1'b0; prev_data = 8'd0;
      forever begin
         @(negedge Clk);
         if (!Rst) begin
            prev_pend = 1'b0; prev_re = 1'b0; prev_err = 1'b0;
         end else begin
            if (ReadEnable) begin
               n_reads++;
               chk(!WriteEnable, "rd_wr_exclusive", 32'(WriteEnable), 32'd0);
               chk(!m_valid, "rd_while_pending", 32'(m_valid), 32'd0);
               chk(!prev_re, "rd_one_cycle", 32'(prev_re), 32'd0);
            end
            if (WriteEnable) begin
               n_writes++;
               chk(Address == 3'h2, "wr_addr", 32'(Address), 32'h2);
               chk(DataIn == 8'h02, "wr_data", 32'(DataIn), 32'h2);
               chk(err_valid, "wr_with_err", 32'(err_valid), 32'd1);
            end
            if (!ReadEnable && !WriteEnable)
               chk({Address, DataIn} == 11'd0, "bus_idle_zero", 32'({Address, DataIn}), 32'd0);
            if (err_valid) begin
               n_errs++;
               last_code = err_code;
               chk(!prev_err, "err_pulse_1cyc", 32'(prev_err), 32'd0);
            end
            if (prev_pend)
               chk({m_valid, m_last, m_data} == {1'b1, prev_last, prev_data}, "stall_hold",
                   32'({m_valid, m_last, m_data}), 32'({1'b1, prev_last, prev_data}));
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) begin
                  chk(1'b0, "unexpected_byte", 32'(m_data), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  chk(m_data == e.d, "byte_data", 32'(m_data), 32'(e.d));
                  chk(m_last == e.l, "byte_last", 32'(m_last), 32'(e.l));
               end
               if (gap_en && acc_total > acc_base)
                  chk(cyc - last_acc_cyc == LAT + 2, "throughput", 32'(cyc - last_acc_cyc), 32'(LAT + 2));
               last_acc_cyc = cyc;
               acc_total++;
            end
            prev_pend = m_valid && !m_ready;
            prev_re   = ReadEnable;
            prev_err  = err_valid;
            prev_data = m_data;
            prev_last = m_last;
         end
      end
   end

   // ---------------- stimulus ----------------
   typedef struct {
      string      name;
      logic [7:0] sc, len, base;
      int         stall_idx, stall_n;
      logic [2:0] code;
      bit         rdy_drop, en_drop;
   } frame_t;

   frame_t tbl[14];

   function automatic logic [27:0] all_outs();
      return {Address, WriteEnable, ReadEnable, DataIn, m_data, m_valid, m_last, err_valid, err_code, busy};
   endfunction

   task automatic push_exp(input logic [7:0] base, input logic [7:0] len);
      exp_t e;
      for (int i = 0; i < int'(len); i++) begin
         e.d = base + 8'(i * 17);
         e.l = (i == int'(len) - 1);
         exp_q.push_back(e);
      end
   endtask

   // Drives m_ready/Rx_Ready/enable per cycle until the frame completes or the budget expires
   task automatic wait_frame(input frame_t f, input int e0);
      int  stall_left;
      bit  done;
      stall_left = f.stall_n;
      done = 1'b0;
      for (int c = 0; c < 2000 && !done; c++) begin
         if (m_valid && (acc_total - acc_base) == f.stall_idx && stall_left > 0) begin
            m_ready = 1'b0;
            stall_left--;
         end else begin
            m_ready = 1'b1;
         end
         if (f.rdy_drop && (acc_total - acc_base) >= 1) Rx_Ready = 1'b0;
         if (f.en_drop && (acc_total - acc_base) >= 1) enable = 1'b0;
         @(posedge Clk); #1;
         done = (f.code == 3'd0) ? ((acc_total - acc_base) == int'(f.len)) : ((n_errs - e0) > 0);
      end
      chk(done, "frame_done", 32'(acc_total - acc_base), 32'(f.len));
      m_ready = 1'b1;
   endtask

   task automatic run_frame(input frame_t f);
      int r0, w0, e0, exp_rd;
      sc_reg = f.sc; len_reg = f.len; base_reg = f.base;
      if (f.code == 3'd0) push_exp(f.base, f.len);
      r0 = n_reads; w0 = n_writes; e0 = n_errs;
      acc_base = acc_total;
      gap_en = (f.stall_n == 0);
      @(posedge Clk); #1;
      Rx_Ready = 1'b1;
      @(posedge Clk); #1;
      chk(ReadEnable && Address == 3'h2, "first_strobe_sc", 32'({ReadEnable, Address}), 32'h0A);
      wait_frame(f, e0);
      Rx_Ready = 1'b0;
      for (int c = 0; c < 10 && busy; c++) begin
         @(posedge Clk); #1;
      end
      chk(!busy, "back_to_idle", 32'(busy), 32'd0);
      exp_rd = (f.code == 3'd0) ? 2 + int'(f.len) : ((f.code == 3'd4) ? 2 : 1);
      chk(n_reads - r0 == exp_rd, "read_count", 32'(n_reads - r0), 32'(exp_rd));
      chk(n_writes - w0 == ((f.code != 3'd0) ? 1 : 0), "write_count", 32'(n_writes - w0), 32'(f.code != 3'd0));
      chk(n_errs - e0 == ((f.code != 3'd0) ? 1 : 0), "err_count", 32'(n_errs - e0), 32'(f.code != 3'd0));
      if (f.code != 3'd0) begin
         chk(last_code == f.code, "err_code", 32'(last_code), 32'(f.code));
         chk(err_code == f.code, "err_code_held", 32'(err_code), 32'(f.code));
         chk(acc_total == acc_base, "no_bytes_on_drop", 32'(acc_total - acc_base), 32'd0);
      end
      chk(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int     r0;
      frame_t f;

      tbl[0]  = '{"good4",      8'h00, 8'd4,   8'hA1, -1, 0, 3'd0, 1'b0, 1'b0};
      tbl[1]  = '{"stall3",     8'h00, 8'd3,   8'h10,  1, 5, 3'd0, 1'b0, 1'b0};
      tbl[2]  = '{"abort",      8'h08, 8'd4,   8'h00, -1, 0, 3'd1, 1'b0, 1'b0};
      tbl[3]  = '{"fcs",        8'h04, 8'd4,   8'h00, -1, 0, 3'd2, 1'b0, 1'b0};
      tbl[4]  = '{"ovf",        8'h10, 8'd4,   8'h00, -1, 0, 3'd3, 1'b0, 1'b0};
      tbl[5]  = '{"prio_abort", 8'h1C, 8'd4,   8'h00, -1, 0, 3'd1, 1'b0, 1'b0};
      tbl[6]  = '{"prio_fcs",   8'h14, 8'd4,   8'h00, -1, 0, 3'd2, 1'b0, 1'b0};
      tbl[7]  = '{"len0",       8'h01, 8'd0,   8'h00, -1, 0, 3'd4, 1'b0, 1'b0};
      tbl[8]  = '{"len127",     8'h01, 8'd127, 8'h00, -1, 0, 3'd4, 1'b0, 1'b0};
      tbl[9]  = '{"len2",       8'h01, 8'd2,   8'h55, -1, 0, 3'd0, 1'b0, 1'b0};
      tbl[10] = '{"len1",       8'h01, 8'd1,   8'h7E, -1, 0, 3'd0, 1'b0, 1'b0};
      tbl[11] = '{"lenmax",     8'h01, 8'd126, 8'h03, -1, 0, 3'd0, 1'b0, 1'b0};
      tbl[12] = '{"rdy_drop",   8'h01, 8'd4,   8'h60, -1, 0, 3'd0, 1'b1, 1'b0};
      tbl[13] = '{"en_drop",    8'h01, 8'd3,   8'h90, -1, 0, 3'd0, 1'b0, 1'b1};

      for (int i = 0; i < LAT; i++) pipe[i] = 8'hEE;

      #2 Rst = 1'b0;
      #1 chk(all_outs() == 28'd0, "reset_outputs", 32'(all_outs()), 32'd0);
      @(posedge Clk); #1;
      Rst = 1'b1;
      enable = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_frame(tbl[i]);
      end

      // enable dropped mid-frame: controller must now stay idle despite Rx_Ready
      r0 = n_reads;
      Rx_Ready = 1'b1;
      repeat (5) @(posedge Clk);
      #1;
      chk(!busy && n_reads == r0, "disabled_stays_idle", 32'({busy, 8'(n_reads - r0)}), 32'd0);
      Rx_Ready = 1'b0;
      enable = 1'b1;
      @(posedge Clk); #1;

      // reset during a len-5 drain, then restart of the same frame from RD_SC
      f = '{"rst_mid", 8'h01, 8'd5, 8'h20, -1, 0, 3'd0, 1'b0, 1'b0};
      sc_reg = f.sc; len_reg = f.len; base_reg = f.base;
      push_exp(f.base, f.len);
      acc_base = acc_total;
      gap_en = 1'b0;
      Rx_Ready = 1'b1;
      for (int c = 0; c < 200 && (acc_total - acc_base) < 2; c++) begin
         @(posedge Clk); #1;
      end
      chk(acc_total - acc_base == 2, "rst_mid_two_bytes", 32'(acc_total - acc_base), 32'd2);
      #2 Rst = 1'b0;
      #1 chk(all_outs() == 28'd0, "rst_mid_outputs", 32'(all_outs()), 32'd0);
      exp_q.delete();
      push_exp(f.base, f.len);
      acc_base = acc_total;
      r0 = n_reads;
      @(posedge Clk); #1;
      Rst = 1'b1;
      @(posedge Clk); #1;
      chk(ReadEnable && Address == 3'h2, "restart_rd_sc", 32'({ReadEnable, Address}), 32'h0A);
      wait_frame(f, n_errs);
      Rx_Ready = 1'b0;
      for (int c = 0; c < 10 && busy; c++) begin
         @(posedge Clk); #1;
      end
      chk(n_reads - r0 == 7, "restart_read_count", 32'(n_reads - r0), 32'd7);
      chk(exp_q.size() == 0, "restart_scoreboard", 32'(exp_q.size()), 32'd0);

`ifdef HDLC_RXDRAIN_STATS_EN
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(posedge Clk); #1;
      Rst = 1'b1;
      chk(frame_cnt == 16'd0 && drop_cnt == 16'd0, "stats_reset", 32'({frame_cnt, drop_cnt}), 32'd0);
      run_frame(tbl[9]);
      run_frame(tbl[2]);
      run_frame(tbl[10]);
      run_frame(tbl[5]);
      run_frame(tbl[0]);
      chk(frame_cnt == 16'd3, "frame_cnt", 32'(frame_cnt), 32'd3);
      chk(drop_cnt == 16'd2, "drop_cnt", 32'(drop_cnt), 32'd2);
`endif

      $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
      $finish;
   end

endmodule
